// File: rtl/linear_layer_fifo_pkg.sv
// Shared helpers for the Linear_Layer start-token FIFOs: occupancy width
// and parameter legality checks used at elaboration time.
package linear_layer_fifo_pkg;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Capacity must be non-zero and addressable, and the count must fit the occupancy.
    function automatic bit params_ok(input int unsigned addr_width, input int unsigned depth);
        return (depth >= 1) && ((64'd1 << addr_width) >= 64'(depth)) &&
               ((addr_width + 1) >= occ_width(depth));
    endfunction

endpackage

// File: rtl/linear_layer_fifo_shiftreg.sv
// Shift-register token storage: a write shifts every slot up by one and
// loads din into slot 0; the read port is combinational.
module linear_layer_fifo_shiftreg #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Addresses beyond the capacity only occur with an oversized ADDR_WIDTH.
    always_comb begin
        dout = '0;
        if (32'(addr) < DEPTH) begin
            dout = mem[addr];
        end
    end

endmodule

// File: rtl/linear_layer_start_fifo_ctrl.sv
// Occupancy controller for a start-token shift-register FIFO: count,
// registered full/empty flags and the read address of the oldest token.
module linear_layer_start_fifo_ctrl
    import linear_layer_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    if (!params_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_params
        $error("linear_layer_start_fifo_ctrl: illegal DEPTH/ADDR_WIDTH combination");
    end

    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Handshakes are qualified only by the registered flags.
    assign wr_acc = if_write & if_write_ce & if_full_n;
    assign rd_acc = if_read & if_read_ce & if_empty_n;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CNT_W'(1);
        end
    end

    // The oldest token sits in the highest occupied slot.
    always_comb begin
        addr = '0;
        if (count != '0) begin
            addr = ADDR_WIDTH'(count - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            count      <= count_next;
            if_empty_n <= (count_next != '0);
            if_full_n  <= (count_next != CNT_W'(DEPTH));
        end
    end

    assign if_num_data_valid = count;
    assign if_fifo_cap       = CNT_W'(DEPTH);

    linear_layer_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .we   (wr_acc & ~reset),
        .addr (addr),
        .din  (if_din),
        .dout (if_dout)
    );

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Directed bench for linear_layer_start_fifo_ctrl at DEPTH=2, DATA_WIDTH=8.
module tb_linear_layer_start_fifo_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 1;
    localparam int unsigned DP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;

    int tests = 0;
    int fails = 0;

    linear_layer_start_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_empty_n        (if_empty_n),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rd);
        if_write = wr;
        if_din   = d;
        if_read  = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (if_empty_n !== 1'b0) begin
                fails++; $display("FAIL reset_empty_n[%0d] got %b exp 0", i, if_empty_n);
            end
            tests++;
            if (if_full_n !== 1'b1) begin
                fails++; $display("FAIL reset_full_n[%0d] got %b exp 1", i, if_full_n);
            end
            tests++;
            if (if_num_data_valid !== 2'd0) begin
                fails++; $display("FAIL reset_count[%0d] got %0d exp 0", i, if_num_data_valid);
            end
            step();
        end
        tests++;
        if (if_fifo_cap !== 2'd2) begin
            fails++; $display("FAIL fifo_cap got %0d exp 2", if_fifo_cap);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] exp_dout [5]  = '{8'hA1, 8'hA1, 8'hA1, 8'hB2, 8'h00};
        logic [1:0]    exp_cnt  [5]  = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
        logic          exp_full [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic          exp_emp  [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic          wr       [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic          rd       [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [DW-1:0] din      [5]  = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            drive(wr[i], din[i], rd[i]);
            step();
            tests++;
            if (if_num_data_valid !== exp_cnt[i]) begin
                fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, if_num_data_valid, exp_cnt[i]);
            end
            tests++;
            if (if_full_n !== exp_full[i] || if_empty_n !== exp_emp[i]) begin
                fails++; $display("FAIL fill_flags[%0d] got full_n=%b empty_n=%b exp %b %b",
                                  i, if_full_n, if_empty_n, exp_full[i], exp_emp[i]);
            end
            if (exp_emp[i]) begin
                tests++;
                if (if_dout !== exp_dout[i]) begin
                    fails++; $display("FAIL fill_dout[%0d] got %h exp %h", i, if_dout, exp_dout[i]);
                end
            end
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wdat [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        logic [DW-1:0] edat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        // Read while empty is ignored; the paired write still lands.
        drive(1'b1, 8'h11, 1'b1);
        step();
        tests++;
        if (if_num_data_valid !== 2'd1 || if_dout !== 8'h11) begin
            fails++; $display("FAIL empty_rw got count=%0d dout=%h exp 1 11", if_num_data_valid, if_dout);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (if_dout !== edat[i]) begin
                fails++; $display("FAIL b2b_dout[%0d] got %h exp %h", i, if_dout, edat[i]);
            end
            drive(1'b1, wdat[i], 1'b1);
            step();
            tests++;
            if (if_num_data_valid !== 2'd1 || if_empty_n !== 1'b1 || if_full_n !== 1'b1) begin
                fails++; $display("FAIL b2b_state[%0d] got count=%0d empty_n=%b full_n=%b exp 1 1 1",
                                  i, if_num_data_valid, if_empty_n, if_full_n);
            end
        end
        tests++;
        if (if_dout !== 8'h55) begin
            fails++; $display("FAIL b2b_last got %h exp 55", if_dout);
        end
        drive(1'b0, 8'h00, 1'b1);
        step();
        tests++;
        if (if_empty_n !== 1'b0 || if_num_data_valid !== 2'd0) begin
            fails++; $display("FAIL b2b_drain got empty_n=%b count=%0d exp 0 0", if_empty_n, if_num_data_valid);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_full_rw();
        drive(1'b1, 8'h61, 1'b0); step();
        drive(1'b1, 8'h62, 1'b0); step();
        tests++;
        if (if_full_n !== 1'b0) begin
            fails++; $display("FAIL full_setup got full_n=%b exp 0", if_full_n);
        end
        // Write blocked by full while the read goes through.
        drive(1'b1, 8'h77, 1'b1); step();
        tests++;
        if (if_num_data_valid !== 2'd1 || if_dout !== 8'h62 || if_full_n !== 1'b1) begin
            fails++; $display("FAIL full_rw got count=%0d dout=%h full_n=%b exp 1 62 1",
                              if_num_data_valid, if_dout, if_full_n);
        end
        drive(1'b1, 8'h77, 1'b0); step();
        tests++;
        if (if_num_data_valid !== 2'd2 || if_dout !== 8'h62 || if_full_n !== 1'b0) begin
            fails++; $display("FAIL full_retry got count=%0d dout=%h full_n=%b exp 2 62 0",
                              if_num_data_valid, if_dout, if_full_n);
        end
        drive(1'b0, 8'h00, 1'b1); step();
        tests++;
        if (if_dout !== 8'h77 || if_num_data_valid !== 2'd1) begin
            fails++; $display("FAIL full_tail got dout=%h count=%0d exp 77 1", if_dout, if_num_data_valid);
        end
        step();
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_ce();
        if_write_ce = 1'b0;
        drive(1'b1, 8'h88, 1'b0); step();
        tests++;
        if (if_num_data_valid !== 2'd0 || if_empty_n !== 1'b0) begin
            fails++; $display("FAIL wce_off got count=%0d empty_n=%b exp 0 0", if_num_data_valid, if_empty_n);
        end
        if_write_ce = 1'b1;
        step();
        if_read_ce = 1'b0;
        drive(1'b0, 8'h00, 1'b1); step(); step();
        tests++;
        if (if_num_data_valid !== 2'd1 || if_dout !== 8'h88 || if_empty_n !== 1'b1) begin
            fails++; $display("FAIL rce_off got count=%0d dout=%h empty_n=%b exp 1 88 1",
                              if_num_data_valid, if_dout, if_empty_n);
        end
        if_read_ce = 1'b1;
        step();
        tests++;
        if (if_num_data_valid !== 2'd0 || if_empty_n !== 1'b0) begin
            fails++; $display("FAIL rce_on got count=%0d empty_n=%b exp 0 0", if_num_data_valid, if_empty_n);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'hA0, 1'b0); step();
        drive(1'b1, 8'hA1, 1'b0); step();
        reset = 1'b1;
        drive(1'b1, 8'h99, 1'b0); step();
        reset = 1'b0;
        tests++;
        if (if_num_data_valid !== 2'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
            fails++; $display("FAIL mid_reset got count=%0d empty_n=%b full_n=%b exp 0 0 1",
                              if_num_data_valid, if_empty_n, if_full_n);
        end
        drive(1'b1, 8'h5A, 1'b0); step();
        tests++;
        if (if_num_data_valid !== 2'd1 || if_dout !== 8'h5A) begin
            fails++; $display("FAIL post_reset_wr got count=%0d dout=%h exp 1 5a", if_num_data_valid, if_dout);
        end
        drive(1'b0, 8'h00, 1'b1); step();
        tests++;
        if (if_empty_n !== 1'b0) begin
            fails++; $display("FAIL post_reset_rd got empty_n=%b exp 0", if_empty_n);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        if_write_ce = 1'b1;
        if_read_ce  = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_rw();
        test_ce();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/linear_layer_start_fifo_ctrl.md
# linear_layer_start_fifo_ctrl

Occupancy controller for the shift-register start-token FIFOs that chain dataflow stages of the Linear_Layer_i4xi4 kernel, e.g. the token passed to each `PE_i4xi4_pack_2x2` instance. It accepts tokens from an upstream stage through a full_n/write handshake and presents the oldest token to the downstream stage through an empty_n/read handshake. It owns the occupancy count, the full/empty flags and the shift-register read address; the storage itself is a shift-register sub-module.

## Interface
- `DATA_WIDTH`, 1, token width in bits.
- `ADDR_WIDTH`, 1, shift-register address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- `DEPTH`, 2, capacity in tokens; must be >= 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `if_write_ce` in 1: write-side clock enable; a write is ignored when low.
- `if_write` in 1: producer write request.
- `if_din` in DATA_WIDTH: token to enqueue.
- `if_full_n` out 1: registered; 1 means there is space for a write.
- `if_read_ce` in 1: read-side clock enable; a read is ignored when low.
- `if_read` in 1: consumer read request.
- `if_dout` out DATA_WIDTH: oldest token; valid only while `if_empty_n` = 1.
- `if_empty_n` out 1: registered; 1 means a token is available.
- `if_num_data_valid` out ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `if_fifo_cap` out ADDR_WIDTH+1: constant equal to DEPTH.

## Operation
- Write accepted (`wr_acc`) when `if_write` & `if_write_ce` & `if_full_n`. Read accepted (`rd_acc`) when `if_read` & `if_read_ce` & `if_empty_n`.
- On `wr_acc`, the shift register shifts: `if_din` enters slot 0 and existing slots move up by one.
- `count` register, ADDR_WIDTH+1 bits:
  - `wr_acc` only: count+1.
  - `rd_acc` only: count-1.
  - Both or neither: count unchanged.
- Shift-register address is count-1 when count > 0, otherwise 0.
- `if_dout` = SRL[addr], combinational from the storage. The oldest token always sits at the top occupied slot.
- Flags are computed from the next value of `count` and registered:
  - `if_empty_n` <= (next_count != 0).
  - `if_full_n` <= (next_count != DEPTH).
- `if_num_data_valid` = count.
- No wrap-around: the shift-register design means no pointer ever wraps. `count` saturates logically because the flags gate further writes and reads.
- Simultaneous read and write while non-empty: the token leaves and a new one enters in the same cycle. Occupancy and address are unchanged, and `if_dout` shows the next-oldest token.
- Write while full: not accepted. Storage and count are unchanged, even if a read is accepted in the same cycle; the slot frees one cycle later.
- Read while empty: not accepted. The state does not change and a write in the same cycle still proceeds.
- DEPTH = 1: the flags alternate full/empty and address is always 0.

## Timing
- Reset values:
  - `if_empty_n` = 0.
  - `if_full_n` = 1.
  - `if_num_data_valid` = 0.
  - `if_dout` is undefined; storage is not reset.
- Reset asserted mid-operation discards all tokens at the next edge. The first write is accepted in the cycle after reset deasserts.
- Write-to-read latency: 1 cycle. A token written at edge t is on `if_dout` with `if_empty_n` = 1 after edge t.
- Throughput: one write and one read per cycle sustained when 0 < count < DEPTH.
- Flag update: the edge following a full/empty transition. Writes and reads are qualified by the registered flags, never by combinational next-state logic.

## Structure
- Shared package `linear_layer_fifo_pkg` holds:
  - the occupancy-width function clog2(DEPTH+1);
  - the parameter legality checks (DEPTH >= 1, 2^ADDR_WIDTH >= DEPTH), evaluated in an elaboration-time assertion.
- Sub-module `linear_layer_fifo_shiftreg`: parameters DATA_WIDTH/ADDR_WIDTH/DEPTH; ports clk, we, addr, din, dout. It has no reset and its read is combinational.
- The controller contains only the count register, the two flag registers and the accept/address logic.

## Test plan
- Reset then idle, DEPTH=2, DATA_WIDTH=8 -> `if_empty_n`=0, `if_full_n`=1, `if_num_data_valid`=0, held while `if_read`=1.
- Write 0xA1 then 0xB2 on consecutive cycles -> after the second edge `if_full_n`=0 and count=2. A third write of 0xC3 is ignored. Reads return 0xA1 then 0xB2, then `if_empty_n`=0.
- With count=1 (0x11), assert read and write (0x22) together for 4 cycles, writing 0x22, 0x33, 0x44, 0x55 -> count stays 1, and `if_dout` sequence is 0x11, 0x22, 0x33, 0x44.
- Full at DEPTH=2: assert read and write of 0x77 together -> read accepted, write rejected, count=1. On the next cycle the write is accepted.
- `if_write`=1 with `if_write_ce`=0, and `if_read`=1 with `if_read_ce`=0 -> no state change.
- Fill to 2, assert `reset` for 1 cycle while writing 0x99 -> count=0 and `if_empty_n`=0 after the edge. 0x99 is not retained.
